fetch_skid_reg: RTL and testbench

Parametrised fetch-to-decode pipeline register for the pipelined RAT core, successor to the plain stall-hold fetch register. It carries instruction and program-address payloads across the stage boundary with a valid/ready handshake and a 2-entry skid buffer, so upstream ready is registered and never combinationally depends on downstream ready. It also supports a branch-flush that squashes in-flight entries and presents a NOP bubble to decode.

---
 rtl/fetch_skid_reg.sv | 86 ++++++++
 tb/tb_fetch_skid_reg.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fetch_skid_reg.sv
// Fetch-to-decode pipeline register with a 2-entry skid buffer and branch flush.
// in_ready and every output come straight from flops; decode sees a NOP bubble whenever main is empty.
module fetch_skid_reg #(
  parameter int                 INSTR_W   = 18,
  parameter int                 ADDR_W    = 10,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [1:0]         count
);
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  addr;
  } pl_t;

  localparam pl_t BUBBLE = '{instr: NOP_INSTR, addr: '0};

  pl_t        main_q, main_n, skid_q, skid_n, in_pl;
  logic       main_vld, main_vld_n, skid_vld, skid_vld_n;
  logic [1:0] cnt_q;
  logic       accept, drain;

  assign in_pl  = '{instr: in_instr, addr: in_addr};
  assign accept = in_valid & ~skid_vld;
  assign drain  = main_vld & out_ready;

  always_comb begin
    main_n     = main_q;
    main_vld_n = main_vld;
    skid_n     = skid_q;
    skid_vld_n = skid_vld;
    if (flush) begin
      main_vld_n = 1'b0;
      skid_vld_n = 1'b0;
    end else if (!main_vld) begin
      main_vld_n = accept;
      main_n     = in_pl;
    end else if (drain) begin
      // skid full implies in_ready was low, so no accept competes here
      if (skid_vld) begin
        main_n     = skid_q;
        skid_vld_n = 1'b0;
      end else begin
        main_vld_n = accept;
        main_n     = in_pl;
      end
    end else if (accept) begin
      skid_n     = in_pl;
      skid_vld_n = 1'b1;
    end
    if (!main_vld_n) main_n = BUBBLE;
    if (!skid_vld_n) skid_n = BUBBLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= BUBBLE;
      skid_q   <= BUBBLE;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      main_q   <= main_n;
      skid_q   <= skid_n;
      main_vld <= main_vld_n;
      skid_vld <= skid_vld_n;
      cnt_q    <= {1'b0, main_vld_n} + {1'b0, skid_vld_n};
    end
  end

  assign in_ready  = ~skid_vld;
  assign out_valid = main_vld;
  assign out_instr = main_q.instr;
  assign out_addr  = main_q.addr;
  assign count     = cnt_q;
endmodule

// File: tb/tb_fetch_skid_reg.sv
// Scoreboard bench: default-width and 32/16-bit instances share stimulus and one in-order payload queue.
module tb_fetch_skid_reg;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [31:0] in_instr = '0;
  logic [15:0] in_addr = '0;

  logic        n_ir, n_ov, w_ir, w_ov;
  logic [17:0] n_oi;
  logic [9:0]  n_oa;
  logic [31:0] w_oi;
  logic [15:0] w_oa;
  logic [1:0]  n_cnt, w_cnt;

  fetch_skid_reg u_n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_ir),
    .in_instr(in_instr[17:0]), .in_addr(in_addr[9:0]), .flush(flush),
    .out_valid(n_ov), .out_ready(out_ready), .out_instr(n_oi), .out_addr(n_oa), .count(n_cnt));

  fetch_skid_reg #(.INSTR_W(32), .ADDR_W(16), .NOP_INSTR(32'h00000013)) u_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_ir),
    .in_instr(in_instr), .in_addr(in_addr), .flush(flush),
    .out_valid(w_ov), .out_ready(out_ready), .out_instr(w_oi), .out_addr(w_oa), .count(w_cnt));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] i; logic [15:0] a; } pl_t;
  pl_t  q[$];
  int   n_chk = 0, n_fail = 0;
  logic mon_en = 1'b0;
  logic exp_rdy = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: checks outputs left by the previous edge, then retires the head on a drain.
  initial forever begin
    @(negedge clk); #2;
    if (mon_en) begin
      logic ev;
      ev = q.size() > 0;
      chk("n_valid", 64'(n_ov), 64'(ev));
      chk("w_valid", 64'(w_ov), 64'(ev));
      chk("n_count", 64'(n_cnt), 64'(q.size()));
      chk("w_count", 64'(w_cnt), 64'(q.size()));
      chk("n_ready", 64'(n_ir), 64'(q.size() < 2));
      chk("w_ready", 64'(w_ir), 64'(q.size() < 2));
      chk("n_instr", 64'(n_oi), ev ? 64'(q[0].i[17:0]) : 64'h0);
      chk("n_addr",  64'(n_oa), ev ? 64'(q[0].a[9:0])  : 64'h0);
      chk("w_instr", 64'(w_oi), ev ? 64'(q[0].i) : 64'h13);
      chk("w_addr",  64'(w_oa), ev ? 64'(q[0].a) : 64'h0);
      exp_rdy = q.size() < 2;
      if (out_ready && ev) void'(q.pop_front());
    end
  end

  // One cycle of stimulus; the model records what the next edge does with it.
  task automatic step(input logic v, input logic [31:0] i, input logic [15:0] a,
                      input logic r, input logic f, output logic acc);
    @(negedge clk);
    in_valid = v; in_instr = i; in_addr = a; out_ready = r; flush = f;
    #3;
    acc = v && exp_rdy;
    if (f) q.delete();
    else if (acc) q.push_back('{i: i, a: a});
  endtask

  task automatic push(input logic [31:0] i, input logic [15:0] a, input logic r);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      step(1'b1, i, a, r, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      n_fail++;
      $display("FAIL push_timeout: got no accept expected accept for %0h", i);
    end
  endtask

  task automatic idle(input int n, input logic r);
    logic acc;
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 16'h0, r, 1'b0, acc);
  endtask

  initial begin
    logic        acc;
    logic [31:0] pi;
    logic [15:0] pa;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    for (int k = 1; k <= 5; k++) push(32'(k), 16'(k - 1), 1'b1);
    idle(3, 1'b1);

    push(32'h0AAAA, 16'h010, 1'b0);
    push(32'h0BBBB, 16'h011, 1'b0);
    step(1'b1, 32'h0CCCC, 16'h012, 1'b0, 1'b0, acc);
    step(1'b1, 32'h0CCCC, 16'h012, 1'b0, 1'b0, acc);
    push(32'h0CCCC, 16'h012, 1'b1);
    idle(4, 1'b1);

    push(32'h12345, 16'h100, 1'b0);
    push(32'h23456, 16'h101, 1'b0);
    step(1'b1, 32'h1FFFF, 16'h3FF, 1'b0, 1'b1, acc);
    idle(4, 1'b1);

    push(32'h0DDDD, 16'h020, 1'b0);
    push(32'h0EEEE, 16'h021, 1'b0);
    @(negedge clk);
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_n_valid", 64'(n_ov), 64'h0);
    chk("rst_w_valid", 64'(w_ov), 64'h0);
    chk("rst_n_instr", 64'(n_oi), 64'h0);
    chk("rst_w_instr", 64'(w_oi), 64'h13);
    chk("rst_n_addr",  64'(n_oa), 64'h0);
    chk("rst_w_addr",  64'(w_oa), 64'h0);
    chk("rst_n_ready", 64'(n_ir), 64'h1);
    chk("rst_w_ready", 64'(w_ir), 64'h1);
    chk("rst_n_count", 64'(n_cnt), 64'h0);
    chk("rst_w_count", 64'(w_cnt), 64'h0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_rdy = 1'b1;
    mon_en = 1'b1;

    pi = $urandom; pa = 16'($urandom);
    for (int k = 0; k < 600; k++) begin
      logic v, r, f;
      v = ($urandom % 4) != 0;
      r = ($urandom % 3) != 0;
      f = ($urandom % 20) == 0 || (flush && ($urandom % 2));
      step(v, pi, pa, r, f, acc);
      if (acc || (v && f)) begin
        pi = $urandom; pa = 16'($urandom);
      end
    end
    idle(5, 1'b1);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
